// File: rtl/matrix_wb_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler: write-select
// codes, scheduler states and the matrix request entry layout.
package matrix_wb_sched_pkg;

   typedef enum logic [1:0] {
      WSEL_NONE  = 2'b00,
      WSEL_REG   = 2'b01,
      WSEL_SLICE = 2'b10,
      WSEL_WHOLE = 2'b11
   } wsel_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_e;

   localparam int MX_DATA_W  = 128;
   localparam int SLICE_W    = 32;
   localparam int MX_ENTRY_W = 1 + 2 + MX_DATA_W;

   // Field order matches the {whole, slice, data} concatenation pushed into the FIFO.
   typedef struct packed {
      logic                 whole;
      logic [1:0]           slice;
      logic [MX_DATA_W-1:0] data;
   } mx_req_t;

   function automatic logic [SLICE_W-1:0] get_slice(input logic [MX_DATA_W-1:0] d,
                                                    input logic [1:0]           idx);
      logic [SLICE_W-1:0] s;
      case (idx)
         2'd0:    s = d[31:0];
         2'd1:    s = d[63:32];
         2'd2:    s = d[95:64];
         default: s = d[127:96];
      endcase
      return s;
   endfunction

endpackage

// File: rtl/matrix_wb_sched_if.sv
// Matrix-unit result handshake: the producer (master) presents a result and
// holds it until the scheduler (slave) raises mx_ready.
interface matrix_wb_sched_if;
   import matrix_wb_sched_pkg::*;

   logic                 mx_valid;
   logic                 mx_ready;
   logic                 mx_whole;
   logic [1:0]           mx_slice;
   logic [MX_DATA_W-1:0] mx_data;

   modport master (output mx_valid, mx_whole, mx_slice, mx_data, input mx_ready);
   modport slave  (input mx_valid, mx_whole, mx_slice, mx_data, output mx_ready);

endinterface

// File: rtl/matrix_wb_sched_mx_req_fifo.sv
// Synchronous request FIFO; the head is read straight from the storage
// registers so the write-port mux sees a stable entry each cycle.
module mx_req_fifo
   import matrix_wb_sched_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = MX_ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/matrix_wb_sched.sv
// Shares the register-file write port between the never-stalled integer
// writeback and buffered matrix-unit results, issued in free cycles.
module matrix_wb_sched
   import matrix_wb_sched_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_we,
   input  logic [4:0]           pipe_rd,
   input  logic [31:0]          pipe_data,
   matrix_wb_sched_if.slave     mx,
   input  logic                 split_mode,
   output logic [1:0]           w_select,
   output logic [4:0]           w_regs_addr,
   output logic [31:0]          w_regs_data,
   output logic [MX_DATA_W-1:0] w_matrix_data,
   output logic                 mx_pending,
   output logic [CNT_W-1:0]     conflict_cnt
);

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic [MX_ENTRY_W-1:0] head_raw;
   mx_req_t               head;
   state_e                state;
   logic [1:0]            cnt;
   logic                  free;

   assign head       = mx_req_t'(head_raw);
   assign mx.mx_ready = rst && !full;
   assign push       = mx.mx_valid && mx.mx_ready;
   assign mx_pending = rst && !empty;
   // A write to x0 is a no-op, so it leaves the slot to the matrix unit.
   assign free       = !(pipe_we && (pipe_rd != 5'd0));

   mx_req_fifo #(
      .DEPTH (DEPTH),
      .W     (MX_ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({mx.mx_whole, mx.mx_slice, mx.mx_data}),
      .full  (full),
      .empty (empty),
      .head  (head_raw)
   );

   always_comb begin
      w_select      = WSEL_NONE;
      w_regs_addr   = '0;
      w_regs_data   = '0;
      w_matrix_data = '0;
      pop           = 1'b0;
      if (rst) begin
         if (!free) begin
            w_select    = WSEL_REG;
            w_regs_addr = pipe_rd;
            w_regs_data = pipe_data;
         end else if (!empty) begin
            case (state)
               IDLE: begin
                  if (!head.whole) begin
                     w_select    = WSEL_SLICE;
                     w_regs_addr = {3'b000, head.slice};
                     w_regs_data = head.data[31:0];
                     pop         = 1'b1;
                  end else if (split_mode) begin
                     w_select    = WSEL_SLICE;
                     w_regs_addr = 5'd0;
                     w_regs_data = get_slice(head.data, 2'd0);
                  end else begin
                     w_select      = WSEL_WHOLE;
                     w_matrix_data = head.data;
                     pop           = 1'b1;
                  end
               end
               SPLIT: begin
                  // The entry stays at the head until its last slice leaves.
                  w_select    = WSEL_SLICE;
                  w_regs_addr = {3'b000, cnt};
                  w_regs_data = get_slice(head.data, cnt);
                  pop         = (cnt == 2'd3);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         conflict_cnt <= '0;
      end else begin
         if (!free && !empty && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
         if (free && !empty) begin
            case (state)
               IDLE: begin
                  if (head.whole && split_mode) begin
                     state <= SPLIT;
                     cnt   <= 2'd1;
                  end
               end
               SPLIT: begin
                  if (cnt == 2'd3) begin
                     state <= IDLE;
                     cnt   <= 2'd0;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_wb_sched.sv
// Scoreboard bench: accepted matrix results expand into expected write events,
// which a negedge monitor pops and compares against the regfile write port.
module tb_matrix_wb_sched;
   import matrix_wb_sched_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               pipe_we;
   logic [4:0]         pipe_rd;
   logic [31:0]        pipe_data;
   logic               split_mode;
   logic [1:0]         w_select;
   logic [4:0]         w_regs_addr;
   logic [31:0]        w_regs_data;
   logic [127:0]       w_matrix_data;
   logic               mx_pending;
   logic [CNT_W-1:0]   conflict_cnt;

   matrix_wb_sched_if mxif ();

   matrix_wb_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_we       (pipe_we),
      .pipe_rd       (pipe_rd),
      .pipe_data     (pipe_data),
      .mx            (mxif),
      .split_mode    (split_mode),
      .w_select      (w_select),
      .w_regs_addr   (w_regs_addr),
      .w_regs_data   (w_regs_data),
      .w_matrix_data (w_matrix_data),
      .mx_pending    (mx_pending),
      .conflict_cnt  (conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   sel;
      logic [4:0]   addr;
      logic [31:0]  d32;
      logic [127:0] d128;
      bit           last;
   } ev_t;

   typedef struct {
      bit           whole;
      logic [1:0]   slice;
      logic [127:0] data;
   } req_t;

   ev_t              exp_q[$];
   req_t             offer_q[$];
   req_t             cur_req;
   int               outstanding  = 0;
   bit               model_ready  = 1'b0;
   logic [CNT_W-1:0] exp_conflict = '0;
   int               vectors      = 0;
   int               miscompares  = 0;

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic req_t mk_req(bit whole, logic [1:0] slice, logic [127:0] data);
      req_t r;
      r.whole = whole;
      r.slice = slice;
      r.data  = data;
      return r;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a slice result is one slice write of data[31:0]; a whole result
   // is one whole write, or four slice writes 0..3 when split mode is on.
   task automatic model_accept(req_t r);
      ev_t e;
      outstanding++;
      if (!r.whole) begin
         e.sel = WSEL_SLICE; e.addr = {3'b000, r.slice}; e.d32 = r.data[31:0];
         e.d128 = '0; e.last = 1'b1;
         exp_q.push_back(e);
      end else if (split_mode) begin
         for (int k = 0; k < 4; k++) begin
            e.sel = WSEL_SLICE; e.addr = 5'(k); e.d32 = r.data[32*k +: 32];
            e.d128 = '0; e.last = (k == 3);
            exp_q.push_back(e);
         end
      end else begin
         e.sel = WSEL_WHOLE; e.addr = '0; e.d32 = '0; e.d128 = r.data; e.last = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic cycle(input bit pwe, input logic [4:0] prd);
      bit acc;
      pipe_we   = pwe;
      pipe_rd   = prd;
      pipe_data = $urandom;
      if (!mxif.mx_valid && offer_q.size() > 0) begin
         cur_req        = offer_q.pop_front();
         mxif.mx_valid  = 1'b1;
         mxif.mx_whole  = cur_req.whole;
         mxif.mx_slice  = cur_req.slice;
         mxif.mx_data   = cur_req.data;
      end
      @(posedge clk);
      acc = rst && mxif.mx_valid && model_ready;
      if (acc) model_accept(cur_req);
      #1;
      if (acc) mxif.mx_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((outstanding > 0 || mxif.mx_valid || offer_q.size() > 0) && n < 60) begin
         cycle(1'b0, 5'd0);
         n++;
      end
      if (n >= 60) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", outstanding);
      end
   endtask

   // Monitor
   initial begin
      ev_t ev;
      bit  blocked;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            outstanding  = 0;
            exp_conflict = '0;
            model_ready  = 1'b0;
            chk("rst_w_select", w_select, WSEL_NONE);
            chk("rst_mx_ready", mxif.mx_ready, 0);
            chk("rst_mx_pending", mx_pending, 0);
            chk("rst_w_regs_addr", w_regs_addr, 0);
            chk("rst_w_regs_data", w_regs_data, 0);
            chk("rst_w_matrix_data", w_matrix_data, 0);
         end else begin
            blocked     = pipe_we && (pipe_rd != 5'd0);
            model_ready = (outstanding < DEPTH);
            chk("mx_ready", mxif.mx_ready, model_ready);
            chk("mx_pending", mx_pending, outstanding > 0);
            chk("conflict_cnt", conflict_cnt, exp_conflict);
            if (blocked) begin
               chk("reg_w_select", w_select, WSEL_REG);
               chk("reg_w_regs_addr", w_regs_addr, pipe_rd);
               chk("reg_w_regs_data", w_regs_data, pipe_data);
               if (outstanding > 0 && exp_conflict != '1) exp_conflict++;
            end else if (exp_q.size() > 0) begin
               ev = exp_q.pop_front();
               chk("mx_w_select", w_select, ev.sel);
               if (ev.sel == WSEL_SLICE) begin
                  chk("slice_w_regs_addr", w_regs_addr, ev.addr);
                  chk("slice_w_regs_data", w_regs_data, ev.d32);
               end else begin
                  chk("whole_w_matrix_data", w_matrix_data, ev.d128);
               end
               if (ev.last) outstanding--;
            end else begin
               chk("idle_w_select", w_select, WSEL_NONE);
            end
         end
      end
   end

   // Stimulus
   initial begin
      pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0; split_mode = 1'b0;
      mxif.mx_valid = 1'b0; mxif.mx_whole = 1'b0; mxif.mx_slice = '0; mxif.mx_data = '0;
      rst = 1'b0;
      repeat (2) cycle(1'b0, 5'd0);
      rst = 1'b1;
      repeat (2) cycle(1'b0, 5'd0);

      // Single slice write
      offer_q.push_back(mk_req(1'b0, 2'd2, {96'h0, 32'hDEADBEEF}));
      repeat (3) cycle(1'b0, 5'd0);

      // Whole write blocked by integer writeback to x5
      offer_q.push_back(mk_req(1'b1, 2'd0, rand128()));
      repeat (4) cycle(1'b1, 5'd5);
      repeat (3) cycle(1'b0, 5'd0);

      // Split whole write with an integer write in the second issue cycle
      split_mode = 1'b1;
      offer_q.push_back(mk_req(1'b1, 2'd0, {32'h4, 32'h3, 32'h2, 32'h1}));
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);
      cycle(1'b1, 5'd7);
      repeat (5) cycle(1'b0, 5'd0);
      drain();
      split_mode = 1'b0;

      // Backpressure: three requests against a blocked port
      offer_q.push_back(mk_req(1'b0, 2'd1, rand128()));
      offer_q.push_back(mk_req(1'b1, 2'd0, rand128()));
      offer_q.push_back(mk_req(1'b0, 2'd3, rand128()));
      repeat (6) cycle(1'b1, 5'd9);
      repeat (8) cycle(1'b0, 5'd0);
      drain();

      // x0 writeback leaves the slot to the matrix unit
      offer_q.push_back(mk_req(1'b0, 2'd1, rand128()));
      cycle(1'b1, 5'd0);
      cycle(1'b1, 5'd0);
      drain();

      // Reset in the middle of a split write
      split_mode = 1'b1;
      offer_q.push_back(mk_req(1'b1, 2'd0, rand128()));
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);
      rst = 1'b0;
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);
      rst = 1'b1;
      repeat (4) cycle(1'b0, 5'd0);
      split_mode = 1'b0;

      // Randomized traffic in both split modes
      for (int phase = 0; phase < 4; phase++) begin
         split_mode = phase[0];
         for (int i = 0; i < 150; i++) begin
            if (offer_q.size() == 0 && !mxif.mx_valid && ($urandom % 3 == 0))
               offer_q.push_back(mk_req(1'($urandom), 2'($urandom), rand128()));
            cycle(($urandom % 100) < 40, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom));
         end
         drain();
      end

      repeat (2) cycle(1'b0, 5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matrix_wb_sched.md
Name: matrix_wb_sched

Overview:
Write-port scheduler in front of the integer/matrix register file. It shares the single write port (w_select, w_regs_addr, w_regs_data, w_matrix_data) between two sources:
- the integer pipeline writeback, which is never stalled;
- the multi-cycle matrix unit, which uses a valid/ready handshake.

Matrix results are buffered in a small FIFO and issued in free write cycles, either as a single slice write or as a whole-matrix write. A whole-matrix write can optionally be split into 4 sequential slice writes. The block also exports a pending flag that decode uses to stall matrix readers.

Parameters:
DEPTH, 2, matrix request FIFO entries (power of 2, >=2)
CNT_W, 16, width of saturating conflict counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
pipe_we  in  1  integer writeback valid (always granted)
pipe_rd  in  5  integer destination register
pipe_data  in  32  integer writeback data
mx_valid  in  1  matrix result valid
mx_ready  out  1  scheduler can accept matrix result
mx_whole  in  1  1: whole-matrix result; 0: single slice
mx_slice  in  2  slice index (mx_whole=0)
mx_data  in  128  result; slice write uses [31:0]; slice k of whole = [32k+31:32k]
split_mode  in  1  1: issue whole-matrix writes as 4 slice writes
w_select  out  2  to regfile: 00 none, 01 reg, 10 slice, 11 whole
w_regs_addr  out  5  to regfile: reg index or {3'b0,slice}
w_regs_data  out  32  to regfile: reg/slice data
w_matrix_data  out  128  to regfile: whole-matrix data
mx_pending  out  1  FIFO non-empty (matrix write outstanding)
conflict_cnt  out  CNT_W  cycles a matrix write was ready but blocked by pipe_we

Behaviour:
Reset:
- While rst=0: FIFO emptied, state IDLE, split counter 0, conflict_cnt 0.
- While rst=0: mx_ready=0, w_select=00, mx_pending=0, all data outputs 0.
- Reset in the middle of a split write discards the partial entry. This is consistent, because the regfile reinitialises the matrix on the same reset.

Handshake:
- Enqueue on the posedge where mx_valid && mx_ready; {mx_whole, mx_slice, mx_data} is captured.
- mx_ready = !full, computed from registered state only. There is no same-cycle pass-through while full, even if a pop happens that cycle.
- The producer must hold mx_valid and its data stable until accepted.

Free slot:
- A cycle is free when !(pipe_we && pipe_rd!=0).
- pipe_we with pipe_rd=0 is a no-op and counts as free. In that case no 01 write is driven; the matrix write takes the slot.

Write port mux (combinational from pipe inputs and registered FIFO head):
- pipe_we && pipe_rd!=0: w_select=01, w_regs_addr=pipe_rd, w_regs_data=pipe_data.
- Else, if the FIFO is non-empty, issue the head per the FSM.
- Else w_select=00.

Latency:
- A result enqueued at edge N can issue at the earliest in cycle N+1 (written at edge N+1).

FSM states: IDLE, SPLIT.
- IDLE, free slot, head is a slice: w_select=10, addr={3'b0,slice}, w_regs_data=head[31:0]; pop.
- IDLE, free slot, head is whole, split_mode=0: w_select=11, w_matrix_data=head data; pop.
- IDLE, free slot, head is whole, split_mode=1: w_select=10, addr=0, data=slice 0; cnt<=1; go to SPLIT. split_mode is sampled only at this point.
- SPLIT, free slot: w_select=10, addr=cnt, data=slice cnt; cnt++. When cnt==3, pop and return to IDLE.
- SPLIT, blocked cycle: hold state and cnt.
- Any state, blocked cycle with FIFO non-empty: conflict_cnt increments, saturating at all-ones.

Other rules:
- Simultaneous push and pop when not full: occupancy is unchanged.
- Entries issue strictly in order, with one matrix write per cycle at most.
- mx_pending stays 1 throughout SPLIT, because the entry is popped only on its last slice.
- Pipeline integer writes are never delayed or reordered.

Decomposition:
- Shared package (alongside existing regfile definitions):
  - w_select encodings WSEL_NONE, WSEL_REG, WSEL_SLICE, WSEL_WHOLE.
  - FSM state encodings IDLE/SPLIT.
  - Matrix request entry width (131 = 1+2+128).
- One sub-module: mx_req_fifo, a synchronous DEPTH-entry FIFO with full/empty and registered head, instantiated once.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then 1 -> w_select=00, mx_ready=1 the first cycle after release, mx_pending=0, conflict_cnt=0.
2. Slice write, no conflict: mx_valid with whole=0, slice=2, data[31:0]=32'hDEADBEEF -> next cycle w_select=10, w_regs_addr=2, w_regs_data=32'hDEADBEEF; mx_pending falls the following cycle.
3. Conflict: whole write (split_mode=0) enqueued while pipe_we=1, rd=5 for 3 cycles -> w_select=01 to x5 for those 3 cycles, then one cycle of w_select=11 with w_matrix_data=mx_data; conflict_cnt=3.
4. Split mode: split_mode=1, whole data {32'h4,32'h3,32'h2,32'h1}, pipe_we pulsed (rd=7) in the 2nd issue cycle -> sequence slice0=1, x7 write, slice1=2, slice2=3, slice3=4 over 5 cycles; mx_pending high until after slice3.
5. Full/backpressure: pipe_we=1, rd!=0 held, 3 matrix requests offered -> first 2 accepted, mx_ready=0, third held. On release, entries issue in order and the third is accepted only after the first pop.
6. x0 and reset mid-op: pipe_we=1, rd=0 with a queued slice -> slice issues that cycle (w_select=10). Assert rst=0 during SPLIT at cnt=2 -> FIFO empty, state IDLE, no further slice writes.
